radix4_fft_sequencer: RTL and testbench
=======================================

Name: radix4_fft_sequencer

Overview:
- Controls one in-place radix-4 DIF FFT over N = 4^LOG4N complex points held in a single-port-per-leg sample RAM.
- Issues 4-operand read addresses and twiddle indices to feed the 3-cycle radix-4 complex-add butterfly.
- Tracks memory plus butterfly pipeline latency and issues matching in-place write-back addresses.
- Sits between the transform-control FSM (start/done) and the RAM/butterfly/twiddle datapath.

Parameters:
- LOG4N, 3, number of radix-4 stages; N = 4^LOG4N (default 64).
- ADDR_W, 2*LOG4N, sample address width.
- MEM_RD_LAT, 1, cycles from rd_en to read data valid at the butterfly inputs.
- BF_LAT, 3, butterfly latency in cycles.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request to begin a transform; accepted only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the final write has completed.
- rd_en  out  1  read strobe, one butterfly per cycle.
- rd_addr0..rd_addr3  out  ADDR_W each  leg m read address = base + m*span.
- tw_idx  out  ADDR_W-2  twiddle base exponent k<<(2*stage), aligned with rd_en.
- stage  out  2  current stage index, 0..LOG4N-1.
- wr_en  out  1  write-back strobe.
- wr_addr0..wr_addr3  out  ADDR_W each  copy of the rd_addr set delayed by L = MEM_RD_LAT+BF_LAT.

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE; busy, done, rd_en and wr_en = 0; all addresses, tw_idx, stage and counters = 0; the delay line is flushed. Reset mid-transform aborts with no further writes.
- States: IDLE, ISSUE, DRAIN, FIN.
- IDLE: start=1 moves to ISSUE with stage=0 and b=0. start is ignored in every other state.
- ISSUE: rd_en=1 every cycle with butterfly index b = 0..N/4-1.
  - span = 4^(LOG4N-1-stage).
  - k = b mod span; group = b / span. Both are bit slices, no divider.
  - base = group*4*span + k.
  - After b = N/4-1, go to DRAIN.
- DRAIN: rd_en=0. Wait until the last wr_en of the stage has been issued.
  - The next cycle goes to ISSUE with stage+1 and b=0, or to FIN if stage = LOG4N-1.
  - No stage reads before the previous stage's writes complete (in-place hazard).
- FIN: done=1 and busy=0 for one cycle, then IDLE.
- Write path: an L-deep shift register of {valid, 4 addresses}. wr_en at cycle c+L for a read at cycle c; back-to-back with no gaps.
- Timing with start accepted at cycle t:
  - Stage s first rd_en at t+1+s*(N/4+L).
  - Final write at t + LOG4N*(N/4+L).
  - done at t + LOG4N*(N/4+L) + 1.
  - Defaults: stage period 20 cycles, done at t+61.
- busy is high from t+1 through the cycle before done.
- Address arithmetic is unsigned ADDR_W and never exceeds N-1. tw_idx is k shifted left by 2*stage, truncated to ADDR_W-2 bits.

Optional Feature:
- Macro: RADIX4_SEQ_PERF_CNT_EN.
- Defined:
  - Adds output cycle_cnt (16 bits). It counts cycles while busy=1 and is frozen at done; it holds that value until the next accepted start clears it.
  - Default count is 60. Reset value is 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset, then idle 5 cycles with start=0 -> busy, done, rd_en, wr_en all 0; addresses 0.
- start at t -> rd_en high t+1..t+16 with stage 0; first two reads have addrs 0,16,32,48 then 1,17,33,49 and tw_idx 0 then 1; wr_en high t+5..t+20 with identical address sequence.
- Same run, stage 1 -> first rd_en at t+21; b=0 addrs 0,4,8,12 with tw 0; b=1 addrs 1,5,9,13 with tw 4; b=4 addrs 16,20,24,28 with tw 0.
- Same run, stage 2 -> rd_en from t+41; b=0 addrs 0,1,2,3; tw_idx always 0; last wr_en at t+60 with addrs 60..63; done pulse at t+61; busy low at t+61.
- start pulsed again at t+30 and rst_n=0 at t+35 -> second start ignored; at t+36 all strobes 0 and state IDLE; a fresh start afterwards runs the full sequence from stage 0.
- With RADIX4_SEQ_PERF_CNT_EN defined -> cycle_cnt = 60 after done, held until the next start, then restarts from 0.

Source files
------------

// File: rtl/radix4_fft_sequencer.sv
// radix4_fft_sequencer
//   Address and control sequencer for one in-place radix-4 DIF FFT over
//   N = 4^LOG4N complex points. It issues one 4-leg butterfly read per cycle
//   with the matching twiddle exponent, then replays the same address set as
//   write-back addresses L = MEM_RD_LAT + BF_LAT cycles later. A stage is not
//   started until every write of the previous stage has been issued, which
//   keeps the in-place update hazard-free.
//
// Optional feature (compile-time macro RADIX4_SEQ_PERF_CNT_EN):
//   adds a 16-bit cycle_cnt output that counts busy cycles of a transform,
//   freezes at done and clears on the next accepted start.
//
// Ports:
//   clk                in   clock, rising edge
//   rst_n              in   synchronous active-low reset
//   start              in   begin a transform (accepted in IDLE only)
//   busy               out  transform in progress
//   done               out  one-cycle pulse after the final write
//   rd_en              out  butterfly read strobe
//   rd_addr0..3        out  leg m read address = base + m*span
//   tw_idx             out  twiddle base exponent k << (2*stage)
//   stage              out  current stage index
//   wr_en              out  write-back strobe
//   wr_addr0..3        out  read address set delayed by L cycles
//   cycle_cnt          out  busy-cycle count (only with the macro defined)

module radix4_fft_sequencer #(
    parameter int LOG4N      = 3,
    parameter int ADDR_W     = 2 * LOG4N,
    parameter int MEM_RD_LAT = 1,
    parameter int BF_LAT     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr0,
    output logic [ADDR_W-1:0] rd_addr1,
    output logic [ADDR_W-1:0] rd_addr2,
    output logic [ADDR_W-1:0] rd_addr3,
    output logic [ADDR_W-3:0] tw_idx,
    output logic [1:0]        stage,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr0,
    output logic [ADDR_W-1:0] wr_addr1,
    output logic [ADDR_W-1:0] wr_addr2,
    output logic [ADDR_W-1:0] wr_addr3
`ifdef RADIX4_SEQ_PERF_CNT_EN
    ,
    output logic [15:0]       cycle_cnt
`endif
);

    localparam int          L          = MEM_RD_LAT + BF_LAT;
    localparam int          BW         = ADDR_W - 2;
    localparam logic [7:0]  TOP_SH     = 8'(2 * (LOG4N - 1));
    localparam logic [1:0]  LAST_STAGE = 2'(LOG4N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] a3;
        logic [ADDR_W-1:0] a2;
        logic [ADDR_W-1:0] a1;
        logic [ADDR_W-1:0] a0;
    } wb_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   b_q, b_d;
    logic [1:0]      stage_q, stage_d;
    wb_t [L-1:0]     pipe_q;

    logic [7:0]        stage_sh;
    logic [7:0]        span_sh;
    logic [BW-1:0]     mask_b;
    logic [BW-1:0]     k_b;
    logic [ADDR_W-1:0] span;
    logic [ADDR_W-1:0] base;
    logic              pending;
    logic              last_wr;

    // span = 4^(LOG4N-1-stage); k and group are the low/high bit fields of b
    // split at log2(span), so base is just group shifted up by two bits.
    always_comb begin
        stage_sh = {5'd0, stage_q, 1'b0};
        span_sh  = TOP_SH - stage_sh;
        mask_b   = ~({BW{1'b1}} << span_sh);
        k_b      = b_q & mask_b;
        span     = {{(ADDR_W-1){1'b0}}, 1'b1} << span_sh;
        base     = ({2'b00, b_q & ~mask_b} << 2) | {2'b00, k_b};
    end

    always_comb begin
        rd_en    = (state_q == ISSUE);
        busy     = (state_q == ISSUE) || (state_q == DRAIN);
        done     = (state_q == FIN);
        stage    = stage_q;
        rd_addr0 = '0;
        rd_addr1 = '0;
        rd_addr2 = '0;
        rd_addr3 = '0;
        tw_idx   = '0;
        if (state_q == ISSUE) begin
            rd_addr0 = base;
            rd_addr1 = base + span;
            rd_addr2 = base + (span << 1);
            rd_addr3 = base + (span << 1) + span;
            tw_idx   = k_b << stage_sh;
        end
    end

    // The stage's last write is the one leaving the delay line while every
    // younger slot is empty.
    always_comb begin
        pending = 1'b0;
        for (int unsigned i = 0; i < L - 1; i++) begin
            pending = pending | pipe_q[i].valid;
        end
        last_wr = pipe_q[L-1].valid && !pending;
    end

    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        stage_d = stage_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    b_d     = '0;
                    stage_d = '0;
                end
            end
            ISSUE: begin
                if (b_q == '1) begin
                    state_d = DRAIN;
                    b_d     = '0;
                end else begin
                    b_d = b_q + BW'(1);
                end
            end
            DRAIN: begin
                if (last_wr) begin
                    if (stage_q == LAST_STAGE) begin
                        state_d = FIN;
                    end else begin
                        state_d = ISSUE;
                        stage_d = stage_q + 2'd1;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
                stage_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            b_q     <= '0;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            stage_q <= stage_d;
        end
    end

    // Read addresses are already zero when rd_en is low, so idle slots carry
    // zero addresses down the delay line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= {rd_en, rd_addr3, rd_addr2, rd_addr1, rd_addr0};
            for (int unsigned i = 1; i < L; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    always_comb begin
        wr_en    = pipe_q[L-1].valid;
        wr_addr0 = pipe_q[L-1].a0;
        wr_addr1 = pipe_q[L-1].a1;
        wr_addr2 = pipe_q[L-1].a2;
        wr_addr3 = pipe_q[L-1].a3;
    end

`ifdef RADIX4_SEQ_PERF_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if ((state_q == IDLE) && start) begin
            cnt_q <= '0;
        end else if (busy) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    always_comb cycle_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_radix4_fft_sequencer.sv
// Self-checking bench for radix4_fft_sequencer (default parameters, N = 64).
module tb_radix4_fft_sequencer;

    localparam int LOG4N  = 3;
    localparam int ADDR_W = 2 * LOG4N;
    localparam int NB     = 16;          // butterflies per stage
    localparam int L      = 4;           // MEM_RD_LAT + BF_LAT
    localparam int P      = NB + L;      // stage period

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              busy, done, rd_en, wr_en;
    logic [ADDR_W-1:0] rd_addr0, rd_addr1, rd_addr2, rd_addr3;
    logic [ADDR_W-1:0] wr_addr0, wr_addr1, wr_addr2, wr_addr3;
    logic [ADDR_W-3:0] tw_idx;
    logic [1:0]        stage;
`ifdef RADIX4_SEQ_PERF_CNT_EN
    logic [15:0]       cycle_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        int         cyc;
        logic [5:0] a3;
        logic [5:0] a2;
        logic [5:0] a1;
        logic [5:0] a0;
    } wr_exp_t;

    wr_exp_t sb[$];

    typedef struct {
        logic       rst_n;
        logic       start;
        logic       busy;
        logic       rd_en;
        logic       wr_en;
        logic       done;
        logic [5:0] addr0;
        logic [3:0] tw;
    } vec_t;

    vec_t vt[16];

    radix4_fft_sequencer #(
        .LOG4N(LOG4N)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .rd_en    (rd_en),
        .rd_addr0 (rd_addr0),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_addr3 (rd_addr3),
        .tw_idx   (tw_idx),
        .stage    (stage),
        .wr_en    (wr_en),
        .wr_addr0 (wr_addr0),
        .wr_addr1 (wr_addr1),
        .wr_addr2 (wr_addr2),
        .wr_addr3 (wr_addr3)
`ifdef RADIX4_SEQ_PERF_CNT_EN
        ,
        .cycle_cnt(cycle_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model for cycle rel after an accepted start (rel = 1 is the
    // first cycle after acceptance). Expected writes go onto the scoreboard.
    task automatic check_cycle(input int rel);
        int      s_exp, b, span, k, g, base, pw;
        wr_exp_t e;
        s_exp = -1;
        b     = 0;
        for (int s = 0; s < LOG4N; s++) begin
            if (rel >= 1 + s * P && rel <= s * P + NB) begin
                s_exp = s;
                b     = rel - 1 - s * P;
            end
        end
        chk("rd_en", 32'(rd_en), 32'(s_exp >= 0));
        chk("busy", 32'(busy), 32'(rel >= 1 && rel <= LOG4N * P));
        chk("done", 32'(done), 32'(rel == LOG4N * P + 1));
        if (s_exp >= 0) begin
            span = 4 ** (LOG4N - 1 - s_exp);
            pw   = 4 ** s_exp;
            k    = b % span;
            g    = b / span;
            base = g * 4 * span + k;
            chk("stage", 32'(stage), 32'(s_exp));
            chk("rd_addr0", 32'(rd_addr0), 32'(base));
            chk("rd_addr1", 32'(rd_addr1), 32'(base + span));
            chk("rd_addr2", 32'(rd_addr2), 32'(base + 2 * span));
            chk("rd_addr3", 32'(rd_addr3), 32'(base + 3 * span));
            chk("tw_idx", 32'(tw_idx), 32'((k * pw) % 16));
            e.cyc = rel + L;
            e.a0  = 6'(base);
            e.a1  = 6'(base + span);
            e.a2  = 6'(base + 2 * span);
            e.a3  = 6'(base + 3 * span);
            sb.push_back(e);
        end
        if (sb.size() > 0 && sb[0].cyc == rel) begin
            e = sb.pop_front();
            chk("wr_en", 32'(wr_en), 32'd1);
            chk("wr_addr0", 32'(wr_addr0), 32'(e.a0));
            chk("wr_addr1", 32'(wr_addr1), 32'(e.a1));
            chk("wr_addr2", 32'(wr_addr2), 32'(e.a2));
            chk("wr_addr3", 32'(wr_addr3), 32'(e.a3));
        end else begin
            chk("wr_en_idle", 32'(wr_en), 32'd0);
        end
`ifdef RADIX4_SEQ_PERF_CNT_EN
        chk("cycle_cnt", 32'(cycle_cnt), 32'((rel <= LOG4N * P + 1) ? rel - 1 : LOG4N * P));
`endif
    endtask

    task automatic run_full();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int rel = 1; rel <= LOG4N * P + 2; rel++) begin
            check_cycle(rel);
            if (rel == 1)  chk("plan_s0_b0_leg1", 32'(rd_addr1), 32'd16);
            if (rel == 2)  chk("plan_s0_b1_leg3", 32'(rd_addr3), 32'd49);
            if (rel == 22) chk("plan_s1_b1_leg3", 32'(rd_addr3), 32'd13);
            if (rel == 22) chk("plan_s1_b1_tw", 32'(tw_idx), 32'd4);
            if (rel == 25) chk("plan_s1_b4_leg0", 32'(rd_addr0), 32'd16);
            if (rel == 41) chk("plan_s2_b0_leg3", 32'(rd_addr3), 32'd3);
            if (rel == 60) chk("plan_last_wr_leg0", 32'(wr_addr0), 32'd60);
            if (rel == 60) chk("plan_last_wr_leg3", 32'(wr_addr3), 32'd63);
            tick();
        end
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            vt[i] = '{rst_n: 1'b1, start: 1'b0, busy: 1'b0, rd_en: 1'b0,
                      wr_en: 1'b0, done: 1'b0, addr0: 6'd0, tw: 4'd0};
        end
        vt[0].rst_n = 1'b0;
        vt[1].rst_n = 1'b0;
        vt[1].start = 1'b1;
        vt[7].start = 1'b1;
        vt[7].busy  = 1'b1;
        vt[7].rd_en = 1'b1;
        vt[8].busy  = 1'b1;
        vt[8].rd_en = 1'b1;
        vt[8].addr0 = 6'd1;
        vt[8].tw    = 4'd1;
        vt[9].busy  = 1'b1;
        vt[9].rd_en = 1'b1;
        vt[9].addr0 = 6'd2;
        vt[9].tw    = 4'd2;
        vt[10].rst_n = 1'b0;

        rst_n = 1'b0;
        start = 1'b0;
        tick();
        tick();

        // Reset, idle, short start and a mid-stage reset that must flush writes.
        for (int i = 0; i < 16; i++) begin
            rst_n = vt[i].rst_n;
            start = vt[i].start;
            tick();
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].busy));
            chk($sformatf("vec%0d_rd_en", i), 32'(rd_en), 32'(vt[i].rd_en));
            chk($sformatf("vec%0d_wr_en", i), 32'(wr_en), 32'(vt[i].wr_en));
            chk($sformatf("vec%0d_done", i), 32'(done), 32'(vt[i].done));
            chk($sformatf("vec%0d_rd_addr0", i), 32'(rd_addr0), 32'(vt[i].addr0));
            chk($sformatf("vec%0d_tw", i), 32'(tw_idx), 32'(vt[i].tw));
            chk($sformatf("vec%0d_wr_addr0", i), 32'(wr_addr0), 32'd0);
            chk($sformatf("vec%0d_stage", i), 32'(stage), 32'd0);
        end
        rst_n = 1'b1;
        start = 1'b0;
        tick();

        run_full();

        for (int i = 0; i < 3; i++) begin
            chk("idle_busy", 32'(busy), 32'd0);
`ifdef RADIX4_SEQ_PERF_CNT_EN
            chk("cnt_hold", 32'(cycle_cnt), 32'd60);
`endif
            tick();
        end

        // Second start mid-run is ignored; reset at rel 35 aborts the transform.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int rel = 1; rel <= 35; rel++) begin
            check_cycle(rel);
            start = (rel == 30);
            if (rel == 35) rst_n = 1'b0;
            tick();
        end
        start = 1'b0;
        chk("abort_rd_en", 32'(rd_en), 32'd0);
        chk("abort_wr_en", 32'(wr_en), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_stage", 32'(stage), 32'd0);
`ifdef RADIX4_SEQ_PERF_CNT_EN
        chk("abort_cnt", 32'(cycle_cnt), 32'd0);
`endif
        rst_n = 1'b1;
        sb.delete();
        tick();
        for (int i = 0; i < 6; i++) begin
            chk("post_abort_wr_en", 32'(wr_en), 32'd0);
            chk("post_abort_rd_en", 32'(rd_en), 32'd0);
            tick();
        end

        run_full();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
